// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: RPN token sequencer in front of a LIFO stack.
// Turns operands into pushes and operators into pop/pop/push sequences.
module rpn_stack_ctrl #(
    parameter int ADDR_BITS = 3,
    parameter int WORD_BITS = 8
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_valid,
    input  logic                 in_is_op,
    input  logic [WORD_BITS-1:0] in_token,
    output logic                 out_ready,
    output logic [1:0]           out_stack_cmd,
    output logic [WORD_BITS-1:0] out_stack_data,
    input  logic [WORD_BITS-1:0] in_stack_top,
    input  logic                 in_stack_ready,
    output logic [WORD_BITS-1:0] out_top,
    output logic [ADDR_BITS:0]   out_depth,
    output logic                 out_error
);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;

    localparam logic [ADDR_BITS:0] CAP = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] TWO = {{(ADDR_BITS-1){1'b0}}, 2'b10};
    localparam logic [ADDR_BITS:0] ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        WAIT_RST,
        IDLE,
        WAIT_PUSH,
        WAIT_A,
        POP_B,
        WAIT_B,
        PUSH_RES
    } state_t;

    state_t               state;
    logic [WORD_BITS-1:0] op_a;
    logic [WORD_BITS-1:0] op_b;
    logic [1:0]           op_code;
    logic [WORD_BITS-1:0] result;
    logic [2*WORD_BITS-1:0] product;

    assign out_top = in_stack_top;
    assign product = op_b * op_a;

    // ALU: B is the deeper operand, every result truncated to the word
    always_comb begin
        result = '0;
        unique case (op_code)
            2'b00: result = op_b + op_a;
            2'b01: result = op_b - op_a;
            2'b10: result = product[WORD_BITS-1:0];
            2'b11: result = op_b & op_a;
            default: result = '0;
        endcase
    end

    // Sequencer: all outputs registered so stack ready never reaches cmd
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state          <= WAIT_RST;
            out_depth      <= '0;
            out_error      <= 1'b0;
            out_stack_cmd  <= CMD_NOP;
            out_stack_data <= '0;
            out_ready      <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            op_code        <= 2'b00;
        end else begin
            out_stack_cmd <= CMD_NOP;
            out_error     <= 1'b0;
            out_ready     <= 1'b0;
            unique case (state)
                WAIT_RST, WAIT_PUSH: begin
                    if (in_stack_ready) begin
                        state     <= IDLE;
                        out_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    out_ready <= 1'b1;
                    if (in_valid) begin
                        if (!in_is_op) begin
                            if (out_depth < CAP) begin
                                out_stack_cmd  <= CMD_PUSH;
                                out_stack_data <= in_token;
                                out_depth      <= out_depth + ONE;
                                out_ready      <= 1'b0;
                                state          <= WAIT_PUSH;
                            end else begin
                                out_error <= 1'b1;
                            end
                        end else if (out_depth < TWO) begin
                            out_error <= 1'b1;
                        end else begin
                            op_a          <= in_stack_top;
                            op_code       <= in_token[1:0];
                            out_stack_cmd <= CMD_POP;
                            out_ready     <= 1'b0;
                            state         <= WAIT_A;
                        end
                    end
                end
                WAIT_A: begin
                    if (in_stack_ready) begin
                        state <= POP_B;
                    end
                end
                POP_B: begin
                    op_b          <= in_stack_top;
                    out_stack_cmd <= CMD_POP;
                    state         <= WAIT_B;
                end
                WAIT_B: begin
                    if (in_stack_ready) begin
                        state <= PUSH_RES;
                    end
                end
                PUSH_RES: begin
                    out_stack_cmd  <= CMD_PUSH;
                    out_stack_data <= result;
                    out_depth      <= out_depth - ONE;
                    state          <= WAIT_PUSH;
                end
                default: begin
                    state <= WAIT_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb_rpn_stack_ctrl: directed checks of rpn_stack_ctrl against a
// behavioural one-cycle-busy stack model.
module tb_rpn_stack_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_is_op;
    logic [7:0] in_token;
    logic       out_ready;
    logic [1:0] cmd;
    logic [7:0] data;
    logic [7:0] stack_top;
    logic       stack_ready;
    logic [7:0] out_top;
    logic [3:0] out_depth;
    logic       out_error;

    int vectors = 0;
    int miscompares = 0;

    rpn_stack_ctrl #(.ADDR_BITS(3), .WORD_BITS(8)) dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_valid       (in_valid),
        .in_is_op       (in_is_op),
        .in_token       (in_token),
        .out_ready      (out_ready),
        .out_stack_cmd  (cmd),
        .out_stack_data (data),
        .in_stack_top   (stack_top),
        .in_stack_ready (stack_ready),
        .out_top        (out_top),
        .out_depth      (out_depth),
        .out_error      (out_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model: one busy cycle after each push or pop
    logic [7:0] mem [0:7];
    logic [3:0] sp;
    logic       busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp   <= 4'd0;
            busy <= 1'b0;
        end else if (busy) begin
            busy <= 1'b0;
        end else if (cmd == 2'b01 && sp < 4'd8) begin
            mem[sp[2:0]] <= data;
            sp           <= sp + 4'd1;
            busy         <= 1'b1;
        end else if (cmd == 2'b10 && sp > 4'd0) begin
            sp   <= sp - 4'd1;
            busy <= 1'b1;
        end
    end

    assign stack_ready = !busy;
    assign stack_top   = (sp == 4'd0) ? 8'h00 : mem[sp[2:0] - 3'd1];

    // Command monitor: log commands and check nop after every command
    int         cyc = 0;
    bit         logging = 0;
    bit         log_push = 0;
    logic [1:0] prev_cmd = 2'b00;
    logic [1:0] cmd_log [$];
    int         push_cyc [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (logging) cmd_log.push_back(cmd);
        if (log_push && cmd == 2'b01) push_cyc.push_back(cyc);
        if (prev_cmd != 2'b00) begin
            vectors = vectors + 1;
            assert (cmd === 2'b00) else begin
                miscompares = miscompares + 1;
                $error("FAIL cmd_then_nop: observed %0h expected 0", cmd);
            end
        end
        prev_cmd = cmd;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (out_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, out_ready}, 32'd1);
    endtask

    task automatic push(input logic [7:0] v);
        wait_ready("push_wait");
        in_valid = 1'b1;
        in_is_op = 1'b0;
        in_token = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Operator with exact latency: busy t+1..t+5, ready and result at t+6
    task automatic op_run(input logic [1:0] code, input logic [7:0] exp_top,
                          input logic [3:0] exp_depth);
        wait_ready("op_wait");
        in_valid = 1'b1;
        in_is_op = 1'b1;
        in_token = {6'd0, code};
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("op_busy", {31'd0, out_ready}, 32'd0);
            @(negedge clk);
        end
        check("op_ready_t6", {31'd0, out_ready}, 32'd1);
        check("op_top", {24'd0, out_top}, {24'd0, exp_top});
        check("op_depth", {28'd0, out_depth}, {28'd0, exp_depth});
    endtask

    // Rejected token: error pulse for one cycle, no command, state held
    task automatic reject(input logic is_op, input logic [7:0] v,
                          input logic [3:0] exp_depth,
                          input logic [7:0] exp_top);
        wait_ready("rej_wait");
        in_valid = 1'b1;
        in_is_op = is_op;
        in_token = v;
        @(negedge clk);
        in_valid = 1'b0;
        check("rej_err_hi", {31'd0, out_error}, 32'd1);
        check("rej_cmd1", {30'd0, cmd}, 32'd0);
        check("rej_ready", {31'd0, out_ready}, 32'd1);
        @(negedge clk);
        check("rej_err_lo", {31'd0, out_error}, 32'd0);
        check("rej_cmd2", {30'd0, cmd}, 32'd0);
        check("rej_depth", {28'd0, out_depth}, {28'd0, exp_depth});
        check("rej_top", {24'd0, out_top}, {24'd0, exp_top});
    endtask

    initial begin
        logic [1:0] exp_seq [0:8];
        int first;
        int idx;
        int n;
        logic ready_s;

        exp_seq[0] = 2'b01; exp_seq[1] = 2'b00; exp_seq[2] = 2'b01;
        exp_seq[3] = 2'b00; exp_seq[4] = 2'b10; exp_seq[5] = 2'b00;
        exp_seq[6] = 2'b10; exp_seq[7] = 2'b00; exp_seq[8] = 2'b01;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_is_op = 1'b0;
        in_token = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_cmd", {30'd0, cmd}, 32'd0);
        check("rst_depth", {28'd0, out_depth}, 32'd0);
        check("rst_ready", {31'd0, out_ready}, 32'd0);
        check("rst_error", {31'd0, out_error}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", {31'd0, out_ready}, 32'd1);

        // 3 4 add: command sequence, latency, result 7
        logging = 1;
        push(8'd3);
        check("push_busy", {31'd0, out_ready}, 32'd0);
        @(negedge clk);
        check("push_ready_t2", {31'd0, out_ready}, 32'd1);
        push(8'd4);
        op_run(2'b00, 8'd7, 4'd1);
        logging = 0;
        first = -1;
        foreach (cmd_log[i]) begin
            if (first < 0 && cmd_log[i] != 2'b00) first = i;
        end
        check("seq_found", {31'd0, first >= 0}, 32'd1);
        if (first >= 0) begin
            for (int i = 0; i < 9; i++) begin
                idx = first + i;
                check("cmd_seq",
                      {30'd0, (idx < cmd_log.size()) ? cmd_log[idx] : 2'b11},
                      {30'd0, exp_seq[i]});
            end
        end

        // sub wraps, mul truncates
        push(8'd2);
        push(8'd5);
        op_run(2'b01, 8'hFD, 4'd2);
        push(8'd16);
        push(8'd17);
        op_run(2'b10, 8'h10, 4'd3);

        // underflow: single operand then operator
        do_reset();
        push(8'd6);
        reject(1'b1, 8'd0, 4'd1, 8'd6);

        // fill to capacity, then overflow
        for (int v = 10; v <= 16; v++) push(8'(v));
        wait_ready("fill_wait");
        check("full_depth", {28'd0, out_depth}, 32'd8);
        check("full_top", {24'd0, out_top}, 32'd16);
        reject(1'b0, 8'd99, 4'd8, 8'd16);

        // reset in WAIT_B after the first pop
        do_reset();
        push(8'd9);
        push(8'd3);
        wait_ready("mid_wait");
        in_valid = 1'b1;
        in_is_op = 1'b1;
        in_token = 8'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_pop_a", {30'd0, cmd}, 32'd2);
        @(negedge clk);
        @(negedge clk);
        check("mid_pop_b", {30'd0, cmd}, 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd", {30'd0, cmd}, 32'd0);
        check("mid_rst_depth", {28'd0, out_depth}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_ready", {31'd0, out_ready}, 32'd1);
        reject(1'b1, 8'd0, 4'd0, 8'd0);

        // streaming operands with in_valid held high
        do_reset();
        push_cyc.delete();
        log_push = 1;
        in_valid = 1'b1;
        in_is_op = 1'b0;
        idx = 1;
        in_token = 8'd1;
        n = 0;
        while (idx <= 4 && n < 40) begin
            ready_s = out_ready;
            @(negedge clk);
            n++;
            if (ready_s) begin
                idx++;
                in_token = 8'(idx);
            end
        end
        in_valid = 1'b0;
        wait_ready("stream_wait");
        log_push = 0;
        check("stream_pushes", push_cyc.size(), 32'd4);
        for (int k = 1; k < 4; k++) begin
            check("stream_gap",
                  (k < push_cyc.size()) ? push_cyc[k] - push_cyc[k-1] : 0,
                  32'd2);
        end
        check("stream_depth", {28'd0, out_depth}, 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("stream_mem", {24'd0, mem[k]}, k + 1);
        end
        push(8'hFF);
        op_run(2'b11, 8'd4, 4'd4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
